// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: obstacle slot pool, move tick, spawn/retire, game FSM, collision and score.
// Optional feature: define SCHED_SPEEDUP_EN to shorten the tick period as the score grows.
module obstacle_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int SCREEN_WIDTH = 640,
  parameter int GROUND_TOP   = 400,
  parameter int AIR_OFFSET   = 15,
  parameter int BLOCK_WIDTH  = 16,
  parameter int PLAYER_X     = 64,
  parameter int TICK_DIV     = 100000,
  parameter int MIN_GAP      = 64
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [Y_W-1:0]           player_y,
  output logic [NUM_SLOTS*X_W-1:0] block_x,
  output logic [NUM_SLOTS*Y_W-1:0] block_y,
  output logic [NUM_SLOTS-1:0]     block_valid,
  output logic [1:0]               state,
  output logic                     tick,
  output logic [15:0]              score
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10
  } state_t;

  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int GAP_W = $clog2(MIN_GAP + 32);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [X_W-1:0] X_SPAWN  = X_W'(SCREEN_WIDTH);
  localparam logic [Y_W-1:0] Y_GROUND = Y_W'(GROUND_TOP);
  localparam logic [Y_W-1:0] Y_AIR    = Y_W'(GROUND_TOP - AIR_OFFSET);
  localparam logic [X_W:0]   PX_LO    = (X_W+1)'(PLAYER_X);
  localparam logic [X_W:0]   PX_HI    = (X_W+1)'(PLAYER_X + BLOCK_WIDTH);
  localparam logic [X_W:0]   BW_X     = (X_W+1)'(BLOCK_WIDTH);
  localparam logic [Y_W:0]   BW_Y     = (Y_W+1)'(BLOCK_WIDTH);
  localparam logic [15:0]    LFSR_TAPS = 16'hB400;

  state_t               state_q;
  logic [X_W-1:0]       x_q     [NUM_SLOTS];
  logic [Y_W-1:0]       y_q     [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q;
  logic [DIV_W-1:0]     div_q;
  logic [GAP_W-1:0]     gap_q;
  logic [15:0]          lfsr_q;

  logic                 collide;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic [15:0]          score_next;
  logic [DIV_W-1:0]     period;
  logic                 div_last;
  logic                 move_tick;

  assign state       = state_q;
  assign block_valid = valid_q;
  assign div_last    = (div_q == period - DIV_W'(1));
  assign move_tick   = (state_q == S_RUN) && !collide && div_last;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign block_x[g*X_W +: X_W] = x_q[g];
    assign block_y[g*Y_W +: Y_W] = y_q[g];
  end

  // Overlap test on the registered positions; the extra x bit keeps x+BLOCK_WIDTH from wrapping.
  always_comb begin
    logic [X_W:0] x_ext;
    logic [Y_W:0] dy;
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    collide = 1'b0;
    x_ext   = '0;
    dy      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      x_ext = {1'b0, x_q[i]};
      dy    = (player_y >= y_q[i]) ? ({1'b0, player_y} - {1'b0, y_q[i]})
                                   : ({1'b0, y_q[i]} - {1'b0, player_y});
      if (valid_q[i] && (x_ext < PX_HI) && (x_ext + BW_X > PX_LO) && (dy < BW_Y))
        collide = 1'b1;
    end
  end

  // Lowest-index free slot, judged before this tick's retirements.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    score_next = score;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (valid_q[i] && (x_q[i] == '0) && (score_next != 16'hFFFF))
        score_next = score_next + 16'd1;
    end
  end

`ifdef SCHED_SPEEDUP_EN
  logic [1:0]       level;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] period_next;

  assign level       = (score >= 16'd48) ? 2'd3 : score[5:4];
  assign period_next = DIV_W'(TICK_DIV - int'(level) * (TICK_DIV / 4));
  assign period      = period_q;

  // The period is only reloaded at a wrap so a running interval is never cut short.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      period_q <= DIV_W'(TICK_DIV);
    else if ((state_q == S_IDLE) && start)
      period_q <= DIV_W'(TICK_DIV);
    else if (move_tick)
      period_q <= period_next;
  end
`else
  assign period = DIV_W'(TICK_DIV);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      lfsr_q <= 16'hACE1;
    else
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      tick    <= 1'b0;
      score   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      valid_q <= '0;
      // NOTE: the slot arrays are a small register pool with defined reset values, so unlike a RAM they are reset.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= X_SPAWN;
        y_q[i] <= Y_GROUND;
      end
    end else begin
      tick <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            div_q   <= '0;
            gap_q   <= '0;
            score   <= '0;
            valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              x_q[i] <= X_SPAWN;
              y_q[i] <= Y_GROUND;
            end
          end
        end
        S_RUN: begin
          if (collide) begin
            state_q <= S_OVER;
          end else if (div_last) begin
            div_q <= '0;
            tick  <= 1'b1;
            score <= score_next;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (valid_q[i]) begin
                if (x_q[i] == '0) valid_q[i] <= 1'b0;
                else              x_q[i]     <= x_q[i] - X_W'(1);
              end
            end
            if (gap_q == '0) begin
              if (free_found) begin
                valid_q[free_idx] <= 1'b1;
                x_q[free_idx]     <= X_SPAWN;
                y_q[free_idx]     <= lfsr_q[0] ? Y_AIR : Y_GROUND;
                gap_q             <= GAP_W'(MIN_GAP) + GAP_W'(lfsr_q[5:1]);
              end
            end else begin
              gap_q <= gap_q - GAP_W'(1);
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_OVER: begin
          if (start) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              x_q[i] <= X_SPAWN;
              y_q[i] <= Y_GROUND;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
